// File: rtl/haar_pkg.sv
// rtl/haar_pkg.sv - shared state encodings and corner-order helpers for the integral window reader
package haar_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd1;
    localparam logic [STATE_W-1:0] ST_ACC_D   = 3'd2;
    localparam logic [STATE_W-1:0] ST_ACC_B   = 3'd3;
    localparam logic [STATE_W-1:0] ST_ACC_C   = 3'd4;
    localparam logic [STATE_W-1:0] ST_ACC_A   = 3'd5;
    localparam logic [STATE_W-1:0] ST_HOLD    = 3'd6;

    typedef enum logic [1:0] {
        CORNER_A = 2'd0,
        CORNER_B = 2'd1,
        CORNER_C = 2'd2,
        CORNER_D = 2'd3
    } corner_e;

    // Which corner each accumulate state consumes (D, then B, C, A).
    function automatic corner_e state_corner(input logic [STATE_W-1:0] st);
        case (st)
            ST_ACC_D: state_corner = CORNER_D;
            ST_ACC_B: state_corner = CORNER_B;
            ST_ACC_C: state_corner = CORNER_C;
            default:  state_corner = CORNER_A;
        endcase
    endfunction

    // B and C are subtracted, A and D are added.
    function automatic logic corner_is_sub(input corner_e c);
        corner_is_sub = (c == CORNER_B) || (c == CORNER_C);
    endfunction

endpackage

// File: rtl/rect_accumulator.sv
// rtl/rect_accumulator.sv - wrapping add/subtract accumulator for the rectangle sum
module rect_accumulator #(
    parameter int SUM_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 en,
    input  logic                 sub,
    input  logic [SUM_WIDTH-1:0] operand,
    output logic [SUM_WIDTH-1:0] result
);

    logic [SUM_WIDTH-1:0] acc_q;
    logic [SUM_WIDTH-1:0] acc_d;

    // Next accumulator value: clear wins, otherwise modular add or subtract.
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sub ? (acc_q - operand) : (acc_q + operand);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result = acc_q;

endmodule

// File: rtl/integral_window_reader.sv
// rtl/integral_window_reader.sv - rectangle sum D-B-C+A from an integral-image window (option: WINDOW_THRESHOLD_EN)
module integral_window_reader
    import haar_pkg::*;
#(
    parameter int DATA_WIDTH_12   = 12,
    parameter int INTEGRAL_WIDTH  = 3,
    parameter int INTEGRAL_HEIGHT = 3,
    parameter int IDX_A           = 0,
    parameter int IDX_B           = 2,
    parameter int IDX_C           = 6,
    parameter int IDX_D           = 8,
    parameter int SUM_WIDTH       = DATA_WIDTH_12 + 2
) (
    input  logic                                                        clk,
    input  logic                                                        reset,
    input  logic [INTEGRAL_WIDTH*INTEGRAL_HEIGHT-1:0][DATA_WIDTH_12-1:0] integral_image,
    input  logic                                                        integral_image_ready,
    output logic                                                        o_window_ack,
    output logic [SUM_WIDTH-1:0]                                        o_rect_sum,
    output logic                                                        o_sum_valid,
`ifdef WINDOW_THRESHOLD_EN
    input  logic signed [SUM_WIDTH-1:0]                                 threshold,
    output logic                                                        o_pass,
`endif
    input  logic                                                        sum_taken
);

    localparam int N_ENTRIES = INTEGRAL_WIDTH * INTEGRAL_HEIGHT;

    if ((IDX_A >= N_ENTRIES) || (IDX_B >= N_ENTRIES) ||
        (IDX_C >= N_ENTRIES) || (IDX_D >= N_ENTRIES)) begin : g_bad_corner_idx
        $error("integral_window_reader: corner index outside the window");
    end

    logic [STATE_W-1:0]               state_q;
    logic [STATE_W-1:0]               state_d;
    logic [3:0][DATA_WIDTH_12-1:0]    corner_q;
    logic [3:0][DATA_WIDTH_12-1:0]    corner_d;
    logic                             acc_clear;
    logic                             acc_en;
    logic                             acc_sub;
    logic [SUM_WIDTH-1:0]             acc_operand;
    logic [SUM_WIDTH-1:0]             acc_result;
    corner_e                          cur_corner;

    // Only the four corner entries feed the datapath; the rest stay unloaded.
    logic unused_window_bits;
    assign unused_window_bits = ^integral_image;

    // Sequencing: capture, four accumulate steps, then hold until taken.
    always_comb begin
        state_d  = state_q;
        corner_d = corner_q;
        case (state_q)
            ST_IDLE: begin
                if (integral_image_ready) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                corner_d[CORNER_A] = integral_image[IDX_A];
                corner_d[CORNER_B] = integral_image[IDX_B];
                corner_d[CORNER_C] = integral_image[IDX_C];
                corner_d[CORNER_D] = integral_image[IDX_D];
                state_d            = ST_ACC_D;
            end
            ST_ACC_D: state_d = ST_ACC_B;
            ST_ACC_B: state_d = ST_ACC_C;
            ST_ACC_C: state_d = ST_ACC_A;
            ST_ACC_A: state_d = ST_HOLD;
            ST_HOLD: begin
                if (sum_taken) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath control derived from the current state.
    always_comb begin
        cur_corner  = state_corner(state_q);
        acc_clear   = (state_q == ST_CAPTURE);
        acc_en      = (state_q == ST_ACC_D) || (state_q == ST_ACC_B) ||
                      (state_q == ST_ACC_C) || (state_q == ST_ACC_A);
        acc_sub     = corner_is_sub(cur_corner);
        acc_operand = SUM_WIDTH'(corner_q[cur_corner]);
    end

    // State and captured-corner registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            corner_q <= '0;
        end else begin
            state_q  <= state_d;
            corner_q <= corner_d;
        end
    end

    rect_accumulator #(
        .SUM_WIDTH (SUM_WIDTH)
    ) u_acc (
        .clk     (clk),
        .reset   (reset),
        .clear   (acc_clear),
        .en      (acc_en),
        .sub     (acc_sub),
        .operand (acc_operand),
        .result  (acc_result)
    );

    assign o_window_ack = (state_q == ST_CAPTURE);
    assign o_sum_valid  = (state_q == ST_HOLD);
    assign o_rect_sum   = acc_result;

`ifdef WINDOW_THRESHOLD_EN
    logic pass_q;
    logic pass_d;

    // Compare the final sum as it is formed so the flag lands with it.
    always_comb begin
        pass_d = pass_q;
        if (state_q == ST_ACC_A) begin
            pass_d = ($signed(acc_result + acc_operand) >= threshold);
        end
    end

    // Threshold flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
        end
    end

    assign o_pass = pass_q;
`endif

endmodule

// File: tb/tb_integral_window_reader.sv
// tb/tb_integral_window_reader.sv - self-checking bench for integral_window_reader (option: WINDOW_THRESHOLD_EN)
module tb_integral_window_reader;

    localparam int DW = 12;
    localparam int NE = 9;
    localparam int SW = 14;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   ready = 1'b0;
    logic                   sum_taken = 1'b0;
    logic [NE-1:0][DW-1:0]  img = '0;
    logic                   ack;
    logic                   valid;
    logic [SW-1:0]          rsum;
`ifdef WINDOW_THRESHOLD_EN
    logic signed [SW-1:0]   threshold = '0;
    logic                   pass;
`endif

    integral_window_reader dut (
        .clk                  (clk),
        .reset                (reset),
        .integral_image       (img),
        .integral_image_ready (ready),
        .o_window_ack         (ack),
        .o_rect_sum           (rsum),
        .o_sum_valid          (valid),
`ifdef WINDOW_THRESHOLD_EN
        .threshold            (threshold),
        .o_pass               (pass),
`endif
        .sum_taken            (sum_taken)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: m_t counts cycles since the ready sample
    // (0 = waiting for a window, 1 = capture cycle, 6 = result held).
    int            m_t = 0;
    logic [SW-1:0] m_sum = '0;
    bit            m_rst = 1'b0;
    bit            checking = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_t   <= 0;
            m_rst <= 1'b1;
        end else begin
            m_rst <= 1'b0;
            if (m_t == 0) begin
                if (ready) m_t <= 1;
            end else if (m_t == 1) begin
                m_sum <= SW'(int'(img[8]) - int'(img[2]) - int'(img[6]) + int'(img[0]));
                m_t   <= 2;
            end else if (m_t < 6) begin
                m_t <= m_t + 1;
            end else if (sum_taken) begin
                m_t <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("ack", ack, 32'(m_t == 1));
            chk("valid", valid, 32'(m_t == 6));
            if (m_t == 6) chk("sum", rsum, m_sum);
            if (m_rst) chk("reset_sum", rsum, 0);
        end
    end

    task automatic scramble();
        for (int i = 0; i < NE; i++) img[i] = DW'($urandom_range(0, 4095));
    endtask

    // Present one window, pulse ready, wait (bounded) for the held result.
    task automatic run_window(input int a, input int b, input int c, input int d,
                              input bit poke, output logic [SW-1:0] s);
        bit ok;
        scramble();
        img[0] = DW'(a);
        img[2] = DW'(b);
        img[6] = DW'(c);
        img[8] = DW'(d);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("ack_cycle1", ack, 1);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid) begin
                ready = 1'b0;
                sum_taken = 1'b0;
                ok = 1'b1;
                break;
            end
            scramble();
            ready = poke;
            sum_taken = poke;
        end
        ready = 1'b0;
        sum_taken = 1'b0;
        if (!ok) chk("valid_timeout", 0, 1);
        s = rsum;
    endtask

    task automatic take();
        sum_taken = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        sum_taken = 1'b0;
        chk("taken_idle", valid, 0);
    endtask

    logic [SW-1:0] s;
    int            last_ack;
    int            nacks;

    initial begin
        repeat (2) @(negedge clk);
        checking = 1'b1;
        chk("rst_ack", ack, 0);
        chk("rst_valid", valid, 0);
        chk("rst_sum", rsum, 0);
        reset = 1'b0;
        @(negedge clk);

        // Entries 1..9: ack one cycle after the sample, sum valid six after.
        for (int i = 0; i < NE; i++) img[i] = DW'(i + 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("t1_ack", ack, 1);
        repeat (4) @(negedge clk);
        chk("t1_not_yet", valid, 0);
        @(negedge clk);
        chk("t1_valid_c6", valid, 1);
        chk("t1_sum", rsum, 14'd0);
        chk("t1_model", m_sum, 14'd0);
        take();

`ifdef WINDOW_THRESHOLD_EN
        threshold = 14'sd40;
`endif
        // 100-30-40+10 = 40, held while sum_taken stays low; ready ignored in HOLD.
        run_window(10, 30, 40, 100, 1'b0, s);
        chk("t2_sum", s, 14'd40);
`ifdef WINDOW_THRESHOLD_EN
        chk("t2_pass_eq", pass, 1);
`endif
        for (int k = 0; k < 5; k++) begin
            scramble();
            ready = 1'b1;
            @(negedge clk);
            chk("t2_hold_sum", rsum, 14'd40);
            chk("t2_hold_valid", valid, 1);
        end
        take();
        @(negedge clk);
        chk("t2_idle_no_ack", ack, 0);
`ifdef WINDOW_THRESHOLD_EN
        threshold = 14'sd41;
        run_window(10, 30, 40, 100, 1'b0, s);
        chk("t2_pass_below", pass, 0);
        take();
`endif

        // Negative wrap, with ready and sum_taken poked during accumulation.
        run_window(0, 4095, 4095, 0, 1'b1, s);
        chk("t3_neg", s, 14'h2002);
        take();

        // Reset in ACC_C discards the partial result.
        scramble();
        img[0] = 12'd1; img[2] = 12'd2; img[6] = 12'd3; img[8] = 12'd100;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        sum_taken = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sum_taken = 1'b0;
        chk("t4_ack0", ack, 0);
        chk("t4_valid0", valid, 0);
        chk("t4_sum0", rsum, 0);
        repeat (6) @(negedge clk);
        chk("t4_no_valid", valid, 0);
        run_window(5, 6, 7, 50, 1'b0, s);
        chk("t4_after", s, 14'd42);
        take();

        // Streaming: one ack every 7 cycles with the window changing each cycle.
        ready = 1'b1;
        sum_taken = 1'b1;
        last_ack = -1;
        nacks = 0;
        for (int cyc = 0; cyc < 36; cyc++) begin
            scramble();
            @(negedge clk);
            if (ack) begin
                if (last_ack >= 0) chk("t5_spacing", cyc - last_ack, 7);
                last_ack = cyc;
                nacks++;
            end
        end
        chk("t5_ack_count", nacks, 6);
        ready = 1'b0;
        sum_taken = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
